// File: rtl/merge_arbiter_pkg.sv
// Shared CGRA interconnect types for the two-input merge arbiter.
// Grant encoding doubles as the registered source tag on the output.
package merge_arbiter_pkg;

    typedef enum logic {
        GRANT_1 = 1'b0,
        GRANT_2 = 1'b1
    } grant_e;

    localparam logic MERGE_MODE_FIXED = 1'b0;
    localparam logic MERGE_MODE_RR    = 1'b1;

    function automatic grant_e other_grant(input grant_e g);
        return (g == GRANT_1) ? GRANT_2 : GRANT_1;
    endfunction

endpackage

// File: rtl/merge_arbiter_rr_grant.sv
// Combinational grant selection for merge_arbiter: fixed priority or
// round-robin with a burst limit. grant[0] = din_1, grant[1] = din_2.
module rr_grant
    import merge_arbiter_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = $clog2(BURST_MAX + 1)
) (
    input  logic [1:0]       valid,
    input  logic             mode,
    input  grant_e           last_grant,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             accept,
    output logic [1:0]       grant
);

    grant_e pick;

    always_comb begin
        pick  = GRANT_1;
        grant = 2'b00;
        if (valid == 2'b11) begin
            // burst_cnt is only zero straight after reset/clear: din_1 opens
            if (mode == MERGE_MODE_FIXED || burst_cnt == '0)
                pick = GRANT_1;
            else if (burst_cnt < CNT_W'(BURST_MAX))
                pick = last_grant;
            else
                pick = other_grant(last_grant);
        end else if (valid[1]) begin
            pick = GRANT_2;
        end
        if (accept && (|valid))
            grant = (pick == GRANT_2) ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/merge_arbiter.sv
// Registered two-input merge arbiter: one-entry output register, source tag,
// and arbitration state (last grant + burst counter) around rr_grant.
module merge_arbiter
    import merge_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] din_1_i,
    input  logic                  din_1_v_i,
    output logic                  din_1_r_o,
    input  logic [DATA_WIDTH-1:0] din_2_i,
    input  logic                  din_2_v_i,
    output logic                  din_2_r_o,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  cout_o,
    output logic                  out_v_o,
    input  logic                  out_r_i
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    logic             accept;
    logic [1:0]       grant;
    grant_e           last_grant;
    grant_e           new_grant;
    logic [CNT_W-1:0] burst_cnt;

    // clr_i blocks any handshake in its own cycle
    assign accept = (~out_v_o | out_r_i) & ~clr_i;

    rr_grant #(
        .BURST_MAX (BURST_MAX),
        .CNT_W     (CNT_W)
    ) u_grant (
        .valid      ({din_2_v_i, din_1_v_i}),
        .mode       (mode_i),
        .last_grant (last_grant),
        .burst_cnt  (burst_cnt),
        .accept     (accept),
        .grant      (grant)
    );

    assign din_1_r_o = grant[0];
    assign din_2_r_o = grant[1];
    assign new_grant = grant[1] ? GRANT_2 : GRANT_1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dout_o     <= '0;
            cout_o     <= 1'b0;
            out_v_o    <= 1'b0;
            last_grant <= GRANT_2;
            burst_cnt  <= '0;
        end else if (clr_i) begin
            out_v_o    <= 1'b0;
            last_grant <= GRANT_2;
            burst_cnt  <= '0;
        end else if (|grant) begin
            dout_o  <= grant[1] ? din_2_i : din_1_i;
            cout_o  <= grant[1];
            out_v_o <= 1'b1;
            if (new_grant == last_grant) begin
                if (burst_cnt != CNT_W'(BURST_MAX))
                    burst_cnt <= burst_cnt + 1'b1;
            end else begin
                last_grant <= new_grant;
                burst_cnt  <= CNT_W'(1);
            end
        end else if (out_r_i) begin
            out_v_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_merge_arbiter.sv
// Self-checking bench for merge_arbiter: directed scenarios plus randomized
// traffic scored against a token-level reference model.
module tb_merge_arbiter;

    localparam int DW = 32;
    localparam int BM = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni, clr_i, mode_i;
    logic [DW-1:0] din_1_i, din_2_i;
    logic          din_1_v_i, din_2_v_i, out_r_i;
    logic          din_1_r_o, din_2_r_o;
    logic [DW-1:0] dout_o;
    logic          cout_o, out_v_o;

    merge_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .mode_i(mode_i),
        .din_1_i(din_1_i), .din_1_v_i(din_1_v_i), .din_1_r_o(din_1_r_o),
        .din_2_i(din_2_i), .din_2_v_i(din_2_v_i), .din_2_r_o(din_2_r_o),
        .dout_o(dout_o), .cout_o(cout_o), .out_v_o(out_v_o), .out_r_i(out_r_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    // reference model: token register + "who holds the bus, for how long"
    bit            m_ov;
    logic [DW-1:0] m_dout;
    bit            m_cout;
    int            m_last, m_cnt, m_g;
    bit            exp_r1, exp_r2;

    task automatic model_reset();
        m_ov = 0; m_dout = '0; m_cout = 0; m_last = 2; m_cnt = 0; m_g = 0;
    endtask

    task automatic model_eval();
        bit acc;
        acc = !m_ov || out_r_i;
        m_g = 0;
        if (!clr_i && acc) begin
            if (din_1_v_i && din_2_v_i) begin
                if (!mode_i || m_cnt == 0) m_g = 1;
                else if (m_cnt < BM)       m_g = m_last;
                else                       m_g = 3 - m_last;
            end else if (din_1_v_i) m_g = 1;
            else if (din_2_v_i)     m_g = 2;
        end
        exp_r1 = (m_g == 1);
        exp_r2 = (m_g == 2);
    endtask

    task automatic model_commit();
        if (clr_i) begin
            m_ov = 0; m_last = 2; m_cnt = 0;
        end else if (m_g != 0) begin
            m_dout = (m_g == 2) ? din_2_i : din_1_i;
            m_cout = (m_g == 2);
            m_ov   = 1;
            if (m_g == m_last) m_cnt = (m_cnt < BM) ? m_cnt + 1 : BM;
            else begin m_last = m_g; m_cnt = 1; end
        end else if (out_r_i) begin
            m_ov = 0;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk_i);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        clr_i = 0; din_1_v_i = 0; din_2_v_i = 0; out_r_i = 1;
    endtask

    task automatic do_clear();
        idle_inputs();
        clr_i = 1;
        tick();
        clr_i = 0;
    endtask

    task automatic test_reset();
        rst_ni = 0; idle_inputs(); mode_i = 0; din_1_i = '0; din_2_i = '0;
        repeat (2) @(posedge clk_i);
        #2;
        model_reset();
        rst_ni = 1;
        #1;
        n_chk++; if (out_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_v got=%b exp=0", out_v_o); end
        n_chk++; if (dout_o !== '0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", dout_o); end
        n_chk++; if (cout_o !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout_o); end
        settle();
        n_chk++; if ({din_2_r_o, din_1_r_o} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", {din_2_r_o, din_1_r_o}); end
    endtask

    task automatic test_single();
        din_1_i = 32'hA5; din_1_v_i = 1; out_r_i = 1;
        settle();
        n_chk++; if (din_1_r_o !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b exp=1", din_1_r_o); end
        tick();
        din_1_v_i = 0;
        n_chk++; if (out_v_o !== 1'b1) begin n_fail++; $display("FAIL single_out_v got=%b exp=1", out_v_o); end
        n_chk++; if (dout_o !== 32'hA5) begin n_fail++; $display("FAIL single_dout got=%h exp=a5", dout_o); end
        n_chk++; if (cout_o !== 1'b0) begin n_fail++; $display("FAIL single_cout got=%b exp=0", cout_o); end
    endtask

    task automatic test_fixed();
        mode_i = 0; din_1_v_i = 1; din_2_v_i = 1; out_r_i = 1;
        for (int i = 0; i < 6; i++) begin
            din_1_i = 32'h100 + i; din_2_i = 32'h200 + i;
            settle();
            n_chk++; if (din_2_r_o !== 1'b0) begin n_fail++; $display("FAIL fixed_r2 cyc=%0d got=%b exp=0", i, din_2_r_o); end
            tick();
            n_chk++; if (cout_o !== 1'b0 || dout_o !== 32'h100 + i) begin
                n_fail++; $display("FAIL fixed_out cyc=%0d got=%b/%h exp=0/%h", i, cout_o, dout_o, 32'h100 + i); end
        end
    endtask

    task automatic test_rr_burst();
        bit [11:0] seq;
        seq = 12'b0000_1111_0000;
        do_clear();
        mode_i = 1; din_1_v_i = 1; din_2_v_i = 1;
        for (int i = 0; i < 12; i++) begin
            din_1_i = 32'h300 + i; din_2_i = 32'h400 + i;
            settle();
            tick();
            n_chk++; if (out_v_o !== 1'b1 || cout_o !== seq[i]) begin
                n_fail++; $display("FAIL rr_burst cyc=%0d got=%b/%b exp=1/%b", i, out_v_o, cout_o, seq[i]); end
        end
    endtask

    task automatic test_rr_resume();
        bit [2:0] seq;
        seq = 3'b011;  // din_2, din_2, then din_1
        do_clear();
        mode_i = 1; din_1_v_i = 0; din_2_v_i = 1;
        for (int i = 0; i < 2; i++) begin
            din_2_i = 32'h500 + i;
            settle(); tick();
            n_chk++; if (cout_o !== 1'b1) begin n_fail++; $display("FAIL rr_resume_pre cyc=%0d got=%b exp=1", i, cout_o); end
        end
        din_2_v_i = 0;
        settle(); tick();
        din_1_v_i = 1; din_2_v_i = 1;
        for (int i = 0; i < 3; i++) begin
            din_1_i = 32'h600 + i; din_2_i = 32'h700 + i;
            settle(); tick();
            n_chk++; if (cout_o !== seq[i]) begin n_fail++; $display("FAIL rr_resume cyc=%0d got=%b exp=%b", i, cout_o, seq[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        mode_i = 0; din_1_v_i = 1; din_2_v_i = 1; out_r_i = 1;
        din_1_i = 32'h800; din_2_i = 32'h900;
        settle(); tick();
        held = dout_o;
        n_chk++; if (held !== 32'h800) begin n_fail++; $display("FAIL bp_load got=%h exp=800", held); end
        out_r_i = 0;
        for (int i = 0; i < 3; i++) begin
            din_1_i = 32'h810 + i; din_2_i = 32'h910 + i;
            settle();
            n_chk++; if ({din_2_r_o, din_1_r_o} !== 2'b00) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%b exp=00", i, {din_2_r_o, din_1_r_o}); end
            tick();
            n_chk++; if (out_v_o !== 1'b1 || dout_o !== 32'h800 || cout_o !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%b exp=1/800/0", i, out_v_o, dout_o, cout_o); end
        end
        out_r_i = 1;
        settle();
        n_chk++; if (din_1_r_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", din_1_r_o); end
        tick();
        n_chk++; if (out_v_o !== 1'b1 || dout_o !== 32'h812) begin
            n_fail++; $display("FAIL bp_release got=%b/%h exp=1/812", out_v_o, dout_o); end
    endtask

    task automatic test_clear();
        mode_i = 1; din_1_v_i = 1; din_2_v_i = 1; out_r_i = 1; clr_i = 1;
        settle();
        n_chk++; if ({din_2_r_o, din_1_r_o} !== 2'b00) begin n_fail++; $display("FAIL clr_ready got=%b exp=00", {din_2_r_o, din_1_r_o}); end
        tick();
        clr_i = 0;
        n_chk++; if (out_v_o !== 1'b0) begin n_fail++; $display("FAIL clr_out_v got=%b exp=0", out_v_o); end
        din_1_i = 32'hA00; din_2_i = 32'hB00;
        settle();
        n_chk++; if ({din_2_r_o, din_1_r_o} !== 2'b01) begin n_fail++; $display("FAIL clr_first_grant got=%b exp=01", {din_2_r_o, din_1_r_o}); end
        tick();
        n_chk++; if (cout_o !== 1'b0 || dout_o !== 32'hA00) begin n_fail++; $display("FAIL clr_first_out got=%b/%h exp=0/a00", cout_o, dout_o); end
    endtask

    task automatic test_async_reset();
        din_1_v_i = 1; din_2_v_i = 0; out_r_i = 1; din_1_i = 32'hC0DE;
        settle(); tick();
        #2 rst_ni = 0;
        #1;
        model_reset();
        n_chk++; if (out_v_o !== 1'b0 || dout_o !== '0) begin n_fail++; $display("FAIL async_reset got=%b/%h exp=0/0", out_v_o, dout_o); end
        idle_inputs();
        @(posedge clk_i);
        #2 rst_ni = 1;
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            din_1_v_i = ($urandom_range(0, 3) != 0);
            din_2_v_i = ($urandom_range(0, 3) != 0);
            din_1_i   = $urandom;
            din_2_i   = $urandom;
            out_r_i   = ($urandom_range(0, 3) != 0);
            clr_i     = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 60) == 0) mode_i = ~mode_i;
            settle();
            n_chk++; if (din_1_r_o !== exp_r1 || din_2_r_o !== exp_r2) begin
                n_fail++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", i, din_2_r_o, din_1_r_o, exp_r2, exp_r1); end
            tick();
            n_chk++; if (out_v_o !== m_ov || (m_ov && (dout_o !== m_dout || cout_o !== m_cout))) begin
                n_fail++; $display("FAIL rand_out cyc=%0d got=%b/%h/%b exp=%b/%h/%b", i, out_v_o, dout_o, cout_o, m_ov, m_dout, m_cout); end
        end
        clr_i = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fixed();
        test_rr_burst();
        test_rr_resume();
        test_backpressure();
        test_clear();
        test_async_reset();
        mode_i = 1;
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/merge_arbiter.md
# merge_arbiter

Registered two-input merge arbiter for the CGRA processing-element interconnect. It shares one elastic output channel between two valid/ready data producers, replacing the combinational merge mode, in which input 1 always wins. It adds fixed-priority or round-robin arbitration with a configurable burst limit and a one-entry output register. It also emits a per-token control bit that identifies the source input, so downstream branch/select logic can steer on it.

## Interface
Parameters:
- DATA_WIDTH, 32, width of data tokens
- BURST_MAX, 4, max consecutive grants to one input in round-robin mode while the other input waits (≥1)

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous clear; drops buffered token, resets arbitration state
- mode_i  in  1  0 = fixed priority (din_1 wins), 1 = round-robin with burst limit
- din_1_i  in  DATA_WIDTH  input 1 data
- din_1_v_i  in  1  input 1 valid
- din_1_r_o  out  1  input 1 ready
- din_2_i  in  DATA_WIDTH  input 2 data
- din_2_v_i  in  1  input 2 valid
- din_2_r_o  out  1  input 2 ready
- dout_o  out  DATA_WIDTH  registered output data
- cout_o  out  1  registered source tag: 0 = token came from din_1, 1 = from din_2
- out_v_o  out  1  output valid
- out_r_i  in  1  output ready

## Operation
- Output stage: single register holding {dout, cout}, qualified by out_v.
- accept = !out_v_o | out_r_i (combinational from out_r_i).
- Grant, evaluated every cycle:
  - If accept is 0, no grant.
  - If accept is 1, grant one valid input, or none if neither is valid.
- din_x_r_o = accept & grant_x. Only the granted input sees ready, so a non-granted producer never loses a token.
- Fixed-priority mode:
  - grant_1 = din_1_v.
  - grant_2 = din_2_v & !din_1_v.
- Round-robin mode, single valid input: that input is granted.
- Round-robin mode, both inputs valid:
  - If burst_cnt < BURST_MAX, grant last_grant (the input holding the bus). Otherwise grant the other input.
  - Exception: directly after reset or clr_i (burst_cnt = 0, last_grant = din_2), din_1 wins.
- State update on each transfer in (accept & any grant):
  - If the granted input equals last_grant, burst_cnt increments, saturating at BURST_MAX.
  - Otherwise last_grant takes the new input and burst_cnt = 1.
- Output register: on a transfer in, it loads the granted data, cout = grant_2, out_v = 1. Otherwise, if out_r_i is 1, out_v clears.
- Mode change while tokens are flowing: takes effect on the next grant decision. The registered token and arbitration state are kept.

## Timing
- Reset values:
  - out_v_o = 0, dout_o = 0, cout_o = 0.
  - last_grant = din_2, burst_cnt = 0.
  - din_1_r_o / din_2_r_o follow the combinational rule (accept = 1 after reset).
- Latency: 1 cycle from input handshake to out_v_o.
- Throughput: 1 token/cycle when out_r_i is held high.
- Backpressure:
  - out_v_o = 1 and out_r_i = 0 → both readies 0.
  - The output register holds dout, cout and out_v stable until out_r_i is 1.
- Simultaneous drain and fill: out_r_i = 1 with a granted valid input → the register reloads in the same cycle; no bubble.
- clr_i has priority over all updates:
  - Next cycle out_v = 0, last_grant = din_2, burst_cnt = 0.
  - Readies are forced to 0 in the clr_i cycle.
- Async reset mid-stream: the buffered token is discarded, and the block restarts from the reset values.
- burst_cnt width: $clog2(BURST_MAX+1). It never exceeds BURST_MAX.

## Structure
- Shared CGRA package gets:
  - typedef grant_e {GRANT_1 = 1'b0, GRANT_2 = 1'b1}
  - constants MERGE_MODE_FIXED = 1'b0 and MERGE_MODE_RR = 1'b1
- One sub-module: rr_grant, the combinational grant logic (inputs: valids, mode, last_grant, burst_cnt, accept). The top level holds the output register and the arbitration state.

## Test plan
- Reset, then din_1 = 0xA5 valid alone, out_r_i = 1 → din_1_r_o = 1 that cycle; next cycle out_v_o = 1, dout_o = 0xA5, cout_o = 0.
- Fixed mode, both inputs continuously valid, out_r_i = 1 for 6 cycles → all 6 outputs have cout_o = 0; din_2_r_o stays 0.
- RR mode, BURST_MAX = 4, both continuously valid → cout sequence 0,0,0,0,1,1,1,1,0,…
- RR mode, din_2 drops valid after 2 grants → last_grant = din_2 with burst_cnt = 2 is kept. When din_2 returns with din_1 still valid, din_2 gets 2 more grants, then a switch to din_1.
- out_r_i = 0 for 3 cycles with a token held, both inputs valid → dout/cout stable, readies 0; on release, the next token follows with no bubble.
- clr_i asserted with out_v_o = 1 → next cycle out_v_o = 0. In RR mode with both inputs valid, the first grant after the clear goes to din_1.
